i2c_if: RTL and testbench

I2C_IF -- requirements
Module: i2c_if

---
 rtl/i2c_if_if.sv | 37 +++
 rtl/i2c_if.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_i2c_if.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_if_if.sv
// ---------------------------------------------------------------------------
// i2c_if_if : bundle of the Wishbone register port and the I2C pad signals
//             used by the i2c_if slave.
//
//   Wishbone : cyc_i, stb_i, we_i, adr_i[1:0], dat_i[7:0]  (host -> slave)
//              dat_o[7:0], ack_o                          (slave -> host)
//   I2C pads : scl_i, sda_i  wired-AND bus levels         (bus -> slave)
//              scl_o, sda_o  open-drain enables, 1=release (slave -> bus)
//
//   modport master : the Wishbone host plus bus side (drives the _i signals)
//   modport slave  : the i2c_if block (drives the _o signals)
// ---------------------------------------------------------------------------
interface i2c_if_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic [1:0]            adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_o;
  logic                  scl_i;
  logic                  sda_i;
  logic                  scl_o;
  logic                  sda_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, scl_i, sda_i,
    input  dat_o, ack_o, scl_o, sda_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, scl_i, sda_i,
    output dat_o, ack_o, scl_o, sda_o
  );
endinterface

// File: rtl/i2c_if.sv
// ---------------------------------------------------------------------------
// i2c_if : 7-bit-address I2C slave with a four-register Wishbone port.
//
//   clk_i : system clock, all logic on the rising edge
//   rst_i : asynchronous active-high reset
//   bus   : i2c_if_if.slave
//           Wishbone  cyc_i/stb_i/we_i/adr_i/dat_i in, dat_o/ack_o out
//           I2C       scl_i/sda_i in, scl_o (always released), sda_o
//
//   Registers (adr_i):
//     0 CFG  rw  [6:0] slave address, [7] enable          reset 0x80
//     1 TXD  rw  byte returned on the next I2C read       reset 0x00
//     2 RXD  ro  last byte written by the I2C master      reset 0x00
//     3 STAT ro  [0] RXV [1] TXD consumed [2] BUSY [3] OP (1 = read)
//   Reading STAT clears RXV and the TXD flag unless a set lands the same cycle.
// ---------------------------------------------------------------------------
module i2c_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic     clk_i,
  input  logic     rst_i,
  i2c_if_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_WR_DATA   = 3'd3,
    S_WR_ACK    = 3'd4,
    S_RD_DATA   = 3'd5,
    S_RD_ACK    = 3'd6,
    S_WAIT_STOP = 3'd7
  } state_t;

  localparam logic [1:0] REG_CFG  = 2'd0;
  localparam logic [1:0] REG_TXD  = 2'd1;
  localparam logic [1:0] REG_RXD  = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  // Synchronizer chains: meta -> sync, plus a one-cycle-delayed copy for edges
  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  sda_q, sda_d;
  logic                  op_q, op_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rxd_q, rxd_d;
  logic                  rxv_q, rxv_d;
  logic                  txf_q, txf_d;
  logic [DATA_WIDTH-1:0] cfg_q, cfg_d;
  logic [DATA_WIDTH-1:0] txd_q, txd_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;

  logic                  scl_rise_s, scl_fall_s, start_s, stop_s;
  logic                  rxv_set_s, txf_set_s, wb_req_s, addr_hit_s;
  logic [DATA_WIDTH-1:0] shift_in_s, stat_s;

  assign scl_rise_s = scl_sync_q & ~scl_prev_q;
  assign scl_fall_s = ~scl_sync_q & scl_prev_q;
  // START/STOP need scl high on both samples so an scl edge is never mistaken
  assign start_s    = scl_sync_q & scl_prev_q & ~sda_sync_q & sda_prev_q;
  assign stop_s     = scl_sync_q & scl_prev_q & sda_sync_q & ~sda_prev_q;

  assign shift_in_s = {sh_q[DATA_WIDTH-2:0], sda_sync_q};
  assign addr_hit_s = cfg_q[DATA_WIDTH-1] &&
                      (shift_in_s[DATA_WIDTH-1:1] == cfg_q[ADDR_WIDTH-1:0]);
  assign stat_s     = {4'b0000, op_q, busy_q, txf_q, rxv_q};
  assign wb_req_s   = bus.cyc_i & bus.stb_i & ~ack_q;

  assign bus.scl_o  = 1'b1;
  assign bus.sda_o  = sda_q;
  assign bus.ack_o  = ack_q;
  assign bus.dat_o  = dat_q;

  // Two-flop synchronizers for the I2C pads plus the delayed edge-detect copy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= bus.scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= bus.sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  // I2C protocol FSM: next state, shift register, bit counter and sda drive
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    sda_d     = sda_q;
    op_d      = op_q;
    busy_d    = busy_q;
    rxd_d     = rxd_q;
    rxv_set_s = 1'b0;
    txf_set_s = 1'b0;
    if (start_s) begin
      state_d = S_ADDR;
      cnt_d   = 4'd0;
      busy_d  = 1'b1;
      sda_d   = 1'b1;
    end else if (stop_s) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      busy_d  = 1'b0;
      sda_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          sda_d = 1'b1;
        end
        S_ADDR: begin
          if (scl_rise_s) begin
            sh_d  = shift_in_s;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (addr_hit_s) begin
                op_d    = sda_sync_q;
                state_d = S_ADDR_ACK;
              end else begin
                state_d = S_WAIT_STOP;
              end
            end else begin
              state_d = S_ADDR;
            end
          end else begin
            state_d = S_ADDR;
          end
        end
        // sda_q is still released on entry, so it marks which ACK fall this is
        S_ADDR_ACK: begin
          if (scl_fall_s) begin
            if (sda_q) begin
              sda_d = 1'b0;
            end else if (op_q) begin
              // Release the ACK and present the MSB of TXD on the same fall
              state_d = S_RD_DATA;
              sda_d   = txd_q[DATA_WIDTH-1];
              sh_d    = {txd_q[DATA_WIDTH-2:0], 1'b0};
              cnt_d   = 4'd1;
            end else begin
              state_d = S_WR_DATA;
              sda_d   = 1'b1;
              cnt_d   = 4'd0;
            end
          end else begin
            state_d = S_ADDR_ACK;
          end
        end
        S_WR_DATA: begin
          if (scl_rise_s) begin
            sh_d  = shift_in_s;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rxd_d     = shift_in_s;
              rxv_set_s = 1'b1;
              state_d   = S_WR_ACK;
            end else begin
              state_d = S_WR_DATA;
            end
          end else begin
            state_d = S_WR_DATA;
          end
        end
        S_WR_ACK: begin
          if (scl_fall_s) begin
            if (sda_q) begin
              sda_d = 1'b0;
            end else begin
              sda_d   = 1'b1;
              state_d = S_WR_DATA;
              cnt_d   = 4'd0;
            end
          end else begin
            state_d = S_WR_ACK;
          end
        end
        // cnt_q counts bits already driven; the fall after the 8th releases sda
        S_RD_DATA: begin
          if (scl_fall_s) begin
            if (cnt_q == 4'd8) begin
              sda_d     = 1'b1;
              txf_set_s = 1'b1;
              state_d   = S_RD_ACK;
            end else begin
              sda_d = sh_q[DATA_WIDTH-1];
              sh_d  = {sh_q[DATA_WIDTH-2:0], 1'b0};
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = S_RD_DATA;
          end
        end
        // On ACK the next byte's MSB waits for the coming fall, keeping sda stable
        S_RD_ACK: begin
          if (scl_rise_s) begin
            if (!sda_sync_q) begin
              state_d = S_RD_DATA;
              sh_d    = txd_q;
              cnt_d   = 4'd0;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end else begin
            state_d = S_RD_ACK;
          end
        end
        S_WAIT_STOP: begin
          sda_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          sda_d   = 1'b1;
        end
      endcase
    end
  end

  // FSM and I2C-side register state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      sh_q    <= 8'h00;
      sda_q   <= 1'b1;
      op_q    <= 1'b0;
      busy_q  <= 1'b0;
      rxd_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      sda_q   <= sda_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      rxd_q   <= rxd_d;
    end
  end

  // Wishbone slave: single-cycle ack, register writes, read mux, flag clear/set
  always_comb begin
    ack_d = wb_req_s;
    dat_d = dat_q;
    cfg_d = cfg_q;
    txd_d = txd_q;
    rxv_d = rxv_q;
    txf_d = txf_q;
    if (wb_req_s) begin
      case (bus.adr_i)
        REG_CFG:  dat_d = cfg_q;
        REG_TXD:  dat_d = txd_q;
        REG_RXD:  dat_d = rxd_q;
        REG_STAT: dat_d = stat_s;
        default:  dat_d = 8'h00;
      endcase
      if (bus.we_i) begin
        case (bus.adr_i)
          REG_CFG: cfg_d = bus.dat_i;
          REG_TXD: txd_d = bus.dat_i;
          default: cfg_d = cfg_q;
        endcase
      end else if (bus.adr_i == REG_STAT) begin
        rxv_d = 1'b0;
        txf_d = 1'b0;
      end else begin
        rxv_d = rxv_q;
      end
    end else begin
      dat_d = dat_q;
    end
    // A set event in the same cycle as a STAT read wins over the clear
    if (rxv_set_s) begin
      rxv_d = 1'b1;
    end else begin
      rxv_d = rxv_d;
    end
    if (txf_set_s) begin
      txf_d = 1'b1;
    end else begin
      txf_d = txf_d;
    end
  end

  // Wishbone-side registers and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= 8'h00;
      cfg_q <= 8'h80;
      txd_q <= 8'h00;
      rxv_q <= 1'b0;
      txf_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      cfg_q <= cfg_d;
      txd_q <= txd_d;
      rxv_q <= rxv_d;
      txf_q <= txf_d;
    end
  end

endmodule

// File: tb/tb_i2c_if.sv
// ---------------------------------------------------------------------------
// tb_i2c_if : directed bench for i2c_if. A bit-banged I2C master and a
// Wishbone host drive the block; expected bytes/ACK bits and register reads
// are queued when issued, and a monitor pops and compares whenever the DUT
// presents a Wishbone read ack or the master collects a byte/ACK from the bus.
// ---------------------------------------------------------------------------
module tb_i2c_if;

  localparam int Q = 4;  // clk cycles per quarter of an I2C bit
  localparam logic [1:0] A_CFG  = 2'd0;
  localparam logic [1:0] A_TXD  = 2'd1;
  localparam logic [1:0] A_RXD  = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic m_scl;
  logic m_sda;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] exp_val_q[$];
  string      exp_tag_q[$];
  logic [7:0] obs_q[$];

  i2c_if_if bus_if ();

  i2c_if dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  // wired-AND bus
  assign bus_if.scl_i = m_scl & bus_if.scl_o;
  assign bus_if.sda_i = m_sda & bus_if.sda_o;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input logic [7:0] act);
    string      tag;
    logic [7:0] e;
    if (exp_val_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got 0x%0h, expected no output", act);
    end else begin
      tag = exp_tag_q.pop_front();
      e   = exp_val_q.pop_front();
      chk(tag, {24'h0, act}, {24'h0, e});
    end
  endtask

  task automatic expect_val(input string tag, input logic [7:0] v);
    exp_tag_q.push_back(tag);
    exp_val_q.push_back(v);
  endtask

  // Monitor: compares every Wishbone read ack and every collected I2C result
  always @(negedge clk) begin
    if (bus_if.ack_o === 1'b1 && bus_if.we_i === 1'b0) sb_pop(bus_if.dat_o);
    while (obs_q.size() > 0) sb_pop(obs_q.pop_front());
  end

  task automatic q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [7:0] d);
    logic got;
    @(posedge clk);
    #1;
    bus_if.cyc_i = 1'b1;
    bus_if.stb_i = 1'b1;
    bus_if.we_i  = we;
    bus_if.adr_i = adr;
    bus_if.dat_i = d;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk);
      #1;
      if (bus_if.ack_o === 1'b1) got = 1'b1;
    end
    bus_if.cyc_i = 1'b0;
    bus_if.stb_i = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wb_timeout: got no ack within 8 cycles, expected ack (adr %0d)", adr);
    end
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [7:0] d);
    wb_xfer(1'b1, adr, d);
  endtask

  task automatic wb_read(input logic [1:0] adr, input logic [7:0] exp, input string tag);
    expect_val(tag, exp);
    wb_xfer(1'b0, adr, 8'h00);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    m_sda = 1'b0; q();
    m_scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; q();
    m_scl = 1'b1; q();
    m_sda = 1'b1; q();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    q();
    m_scl = 1'b1; q(); q();
    m_scl = 1'b0; q();
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    b = bus_if.sda_i; q();
    m_scl = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] v, input logic exp_ack, input string tag);
    logic a;
    expect_val(tag, {7'h00, exp_ack});
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(a);
    obs_q.push_back({7'h00, a});
  endtask

  task automatic read_byte(input logic [7:0] exp);
    logic [7:0] v;
    logic       b;
    expect_val("rd_byte", exp);
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      v = {v[6:0], b};
    end
    obs_q.push_back(v);
  endtask

  task automatic do_write(input logic [6:0] sa, input logic [7:0] d);
    i2c_start();
    write_byte({sa, 1'b0}, 1'b0, "wr_addr_ack");
    write_byte(d, 1'b0, "wr_data_ack");
    i2c_stop();
  endtask

  // ack=1: master ACKs then releases sda during that high phase (STOP)
  task automatic do_read(input logic [6:0] sa, input logic [7:0] exp, input logic ack);
    i2c_start();
    write_byte({sa, 1'b1}, 1'b0, "rd_addr_ack");
    read_byte(exp);
    if (ack) begin
      m_sda = 1'b0; q();
      m_scl = 1'b1; q(); q();
      m_sda = 1'b1; q();
    end else begin
      send_bit(1'b1);
      i2c_stop();
    end
  endtask

  initial begin
    logic b;
    rst          = 1'b1;
    m_scl        = 1'b1;
    m_sda        = 1'b1;
    bus_if.cyc_i = 1'b0;
    bus_if.stb_i = 1'b0;
    bus_if.we_i  = 1'b0;
    bus_if.adr_i = 2'd0;
    bus_if.dat_i = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_sda_o", {31'h0, bus_if.sda_o}, 32'h1);
    chk("rst_scl_o", {31'h0, bus_if.scl_o}, 32'h1);
    chk("rst_ack_o", {31'h0, bus_if.ack_o}, 32'h0);
    chk("rst_dat_o", {24'h0, bus_if.dat_o}, 32'h0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    wb_read(A_CFG,  8'h80, "rst_cfg");
    wb_read(A_TXD,  8'h00, "rst_txd");
    wb_read(A_RXD,  8'h00, "rst_rxd");
    wb_read(A_STAT, 8'h00, "rst_stat");

    // Write transfers
    for (int i = 0; i < 32; i++) begin
      do_write(7'h00, 8'(i));
      wb_read(A_RXD,  8'(i), "wr_rxd");
      wb_read(A_STAT, 8'h01, "wr_stat");
    end

    // Read transfers, master ACKs then STOPs
    for (int i = 0; i < 32; i++) begin
      wb_write(A_TXD, 8'(100 + i));
      do_read(7'h00, 8'(100 + i), 1'b1);
      wb_read(A_STAT, 8'h0A, "rd_stat");
    end

    // Interleaved write/read traffic
    for (int i = 0; i < 64; i++) begin
      do_write(7'h00, 8'(64 + i));
      wb_read(A_RXD,  8'(64 + i), "il_rxd");
      wb_read(A_STAT, 8'h01, "il_wr_stat");
      wb_write(A_TXD, 8'(63 - i));
      do_read(7'h00, 8'(63 - i), (i % 2) == 0);
      wb_read(A_STAT, 8'h0A, "il_rd_stat");
    end

    // Address mismatch: no ACK, parked until STOP with BUSY held
    wb_write(A_CFG, 8'h85);
    wb_read(A_CFG, 8'h85, "cfg_rb");
    i2c_start();
    write_byte(8'h00, 1'b1, "mm_addr_nack");
    write_byte(8'hAA, 1'b1, "mm_data_nack");
    wb_read(A_STAT, 8'h0C, "mm_stat_busy");
    i2c_stop();
    wb_read(A_RXD,  8'h7F, "mm_rxd_kept");
    wb_read(A_STAT, 8'h08, "mm_stat_idle");
    do_write(7'h05, 8'h33);
    wb_read(A_RXD,  8'h33, "addr5_rxd");
    wb_read(A_STAT, 8'h01, "addr5_stat");

    // Disabled block never ACKs, even its own address
    wb_write(A_CFG, 8'h05);
    i2c_start();
    write_byte(8'h0A, 1'b1, "dis_addr_nack");
    i2c_stop();
    wb_read(A_RXD,  8'h33, "dis_rxd_kept");
    wb_read(A_STAT, 8'h00, "dis_stat");
    wb_write(A_CFG, 8'h80);

    // Repeated START inside a write byte re-enters address phase
    i2c_start();
    write_byte(8'h00, 1'b0, "rs_addr1_ack");
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    i2c_start();
    write_byte(8'h00, 1'b0, "rs_addr2_ack");
    write_byte(8'h5A, 1'b0, "rs_data_ack");
    i2c_stop();
    wb_read(A_RXD,  8'h5A, "rs_rxd");
    wb_read(A_STAT, 8'h01, "rs_stat");

    // Reset in the middle of a read byte
    wb_write(A_TXD, 8'h00);
    i2c_start();
    write_byte(8'h01, 1'b0, "mr_addr_ack");
    for (int i = 0; i < 3; i++) begin
      recv_bit(b);
      chk("mr_bit", {31'h0, b}, 32'h0);
    end
    chk("mr_sda_driven", {31'h0, bus_if.sda_o}, 32'h0);
    rst = 1'b1;
    #1;
    chk("mr_sda_released", {31'h0, bus_if.sda_o}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    wb_read(A_CFG,  8'h80, "mr_cfg");
    wb_read(A_RXD,  8'h00, "mr_rxd");
    wb_read(A_STAT, 8'h00, "mr_stat");
    do_write(7'h00, 8'hC3);
    wb_read(A_RXD,  8'hC3, "post_rxd");
    wb_read(A_STAT, 8'h01, "post_wr_stat");
    wb_write(A_TXD, 8'h96);
    do_read(7'h00, 8'h96, 1'b1);
    wb_read(A_STAT, 8'h0A, "post_rd_stat");

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drain", exp_val_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
